// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the core data-port adapter: width codes, FSM states,
// lane masks and the small helpers that derive them.
package riscv_mem_pkg;

  localparam logic [1:0] WIDTH_BYTE    = 2'd0;
  localparam logic [1:0] WIDTH_HALF    = 2'd1;
  localparam logic [1:0] WIDTH_WORD    = 2'd2;
  localparam logic [1:0] WIDTH_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH0  = 2'd1,
    ST_PH1  = 2'd2
  } state_e;

  localparam logic [3:0]  BE_BYTE    = 4'b0001;
  localparam logic [3:0]  BE_HALF    = 4'b0011;
  localparam logic [3:0]  BE_WORD    = 4'b1111;
  localparam logic [31:0] DMASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] DMASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] DMASK_WORD = 32'hFFFF_FFFF;

  // The illegal code is handled as a word everywhere it reaches the datapath.
  function automatic logic [3:0] base_be(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return BE_BYTE;
      WIDTH_HALF: return BE_HALF;
      default:    return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] data_mask(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return DMASK_BYTE;
      WIDTH_HALF: return DMASK_HALF;
      default:    return DMASK_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return offset == 2'd3;
      default:    return offset != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_adapter_if.sv
// Core-side and memory-side signals of the data bus adapter.
interface data_bus_adapter_if #(
  parameter int ADDR_W = 30
);
  // Core side: core_read/core_write form a held request that completes in the
  // cycle core_ready = 1. Memory side: mem_req is held until the cycle with
  // mem_ack = 1, which may be the first cycle of mem_req.
  logic [31:0]       core_address;
  logic [1:0]        core_width;
  logic [31:0]       core_wdata;
  logic              core_read;
  logic              core_write;
  logic [31:0]       core_rdata;
  logic              core_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              misalign_err;

  modport master (
    input  core_address, core_width, core_wdata, core_read, core_write,
    input  mem_rdata, mem_ack,
    output core_rdata, core_ready, misalign_err,
    output mem_addr, mem_req, mem_we, mem_be, mem_wdata
  );

  modport slave (
    output core_address, core_width, core_wdata, core_read, core_write,
    output mem_rdata, mem_ack,
    input  core_rdata, core_ready, misalign_err,
    input  mem_addr, mem_req, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/lane_align.sv
// Combinational lane steering: byte enables, lane-shifted store data, the
// low bytes of a split load and the right-aligned load result.
module lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  width_i,
  input  logic        phase1_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] lo_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] lo_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be_wide;
  logic [4:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] mask;

  // Upper nibble of the widened mask holds the lanes spilling into the next word.
  assign be_wide = {4'b0000, base_be(width_i)} << offset_i;
  assign sh_lo   = {offset_i, 3'b000};
  assign sh_hi   = 6'd32 - {1'b0, sh_lo};
  assign mask    = data_mask(width_i);
  assign lo_o    = rdata_i >> sh_lo;

  always_comb begin
    be_o    = be_wide[3:0];
    wdata_o = wdata_i << sh_lo;
    rdata_o = (rdata_i >> sh_lo) & mask;
    if (phase1_i) begin
      be_o    = be_wide[7:4];
      wdata_o = wdata_i >> sh_hi;
      rdata_o = (lo_i | (rdata_i << sh_hi)) & mask;
    end
  end

endmodule

// File: rtl/data_bus_adapter.sv
// Converts byte-addressed, width-coded core requests into word transactions with
// byte enables. Define MISALIGNED_SPLIT_EN to split word-crossing accesses in two.
module data_bus_adapter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic               clock,
  input  logic               reset,
  data_bus_adapter_if.master bus,
  output state_e             state_o
);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [1:0]        width_q, width_d;
  logic              we_q, we_d;

  logic [ADDR_W-1:0] word_addr;
  logic              illegal, misalign, reject, split, phase1;
  logic              done, accept;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_lo, al_rdata;

  logic [31:0]       core_rdata_c;
  logic              misalign_err_c;
  logic              mem_req_c, mem_we_c;
  logic [3:0]        mem_be_c;
  logic [31:0]       mem_wdata_c;
  logic [ADDR_W-1:0] mem_addr_c;

  assign word_addr = addr_q[ADDR_W+1:2];
  assign illegal   = (width_q == WIDTH_ILLEGAL);
  assign misalign  = is_misaligned(width_q, addr_q[1:0]);
  assign phase1    = (state_q == ST_PH1);

`ifdef MISALIGNED_SPLIT_EN
  assign reject = illegal;
  assign split  = misalign & ~illegal;
`else
  assign reject = illegal | misalign;
  assign split  = 1'b0;
`endif

  lane_align u_lane_align (
    .offset_i (addr_q[1:0]),
    .width_i  (width_q),
    .phase1_i (phase1),
    .wdata_i  (wdata_q),
    .rdata_i  (bus.mem_rdata),
    .lo_i     (lo_q),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .lo_o     (al_lo),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      width_q <= width_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    lo_d           = lo_q;
    width_d        = width_q;
    we_d           = we_q;
    done           = 1'b0;
    accept         = 1'b0;
    core_rdata_c   = '0;
    misalign_err_c = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_be_c       = '0;
    mem_wdata_c    = '0;
    mem_addr_c     = '0;

    case (state_q)
      ST_PH0: begin
        mem_addr_c = word_addr;
        // Rejected accesses complete at once and never touch memory.
        if (reject) begin
          done           = 1'b1;
          misalign_err_c = 1'b1;
        end else begin
          mem_req_c   = 1'b1;
          mem_we_c    = we_q;
          mem_be_c    = al_be;
          mem_wdata_c = al_wdata;
          if (bus.mem_ack) begin
            lo_d = al_lo;
            if (split) begin
              state_d = ST_PH1;
            end else begin
              done         = 1'b1;
              core_rdata_c = we_q ? 32'h0 : al_rdata;
            end
          end
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ST_PH1: begin
        mem_addr_c  = word_addr + ADDR_W'(1);
        mem_req_c   = 1'b1;
        mem_we_c    = we_q;
        mem_be_c    = al_be;
        mem_wdata_c = al_wdata;
        if (bus.mem_ack) begin
          done         = 1'b1;
          core_rdata_c = we_q ? 32'h0 : al_rdata;
        end
      end
`endif
      default: ;
    endcase

    if (done) state_d = ST_IDLE;

    // A completing access can hand over directly to the next request.
    accept = (bus.core_read | bus.core_write) & ((state_q == ST_IDLE) | done);
    if (accept) begin
      addr_d  = bus.core_address;
      width_d = bus.core_width;
      wdata_d = bus.core_wdata;
      we_d    = bus.core_write;
      state_d = ST_PH0;
    end
  end

  assign bus.core_ready   = done;
  assign bus.core_rdata   = core_rdata_c;
  assign bus.misalign_err = misalign_err_c;
  assign bus.mem_req      = mem_req_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_be       = mem_be_c;
  assign bus.mem_wdata    = mem_wdata_c;
  assign bus.mem_addr     = mem_addr_c;
  assign state_o          = state_q;

endmodule

// File: tb/tb_data_bus_adapter.sv
// Directed bench for data_bus_adapter: byte-level reference model, memory
// responder with programmable ack delay, per-cycle compare, final report.
module tb_data_bus_adapter;
  import riscv_mem_pkg::*;

  logic   clock;
  logic   reset;
  state_e state_o;

  data_bus_adapter_if #(.ADDR_W(30)) bus ();

  data_bus_adapter #(.ADDR_W(30)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [66:0] exp_mem_q[$];   // {word addr, we, be, wdata on enabled lanes}
  logic [33:0] exp_rsp_q[$];   // {check rdata, misalign_err, rdata}
  logic [31:0] mem_m [logic [29:0]];

  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          txn_cnt   = 0;
  int          last_waits;
  logic [29:0] last_addr;
  logic [3:0]  last_be, prev_be;
  logic [31:0] last_wdata, last_rdata;
  logic        last_we, last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return {2'b00, wa} ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] ba);
    logic [31:0] wv;
    wv = mem_rd(ba[31:2]);
    return wv[8*ba[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Expected word transactions and core response, built byte by byte.
  task automatic model_request(input logic [31:0] a, input logic [1:0] w,
                               input logic [31:0] wd, input logic is_wr);
    int          n;
    logic [31:0] ba, rd, wd0, wd1;
    logic [3:0]  be0, be1;
    logic [29:0] wa0;
    bit          crosses, split_ok;
    n       = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    crosses = (int'(a[1:0]) + n) > 4;
`ifdef MISALIGNED_SPLIT_EN
    split_ok = 1'b1;
`else
    split_ok = 1'b0;
`endif
    if (w == 2'd3 || (crosses && !split_ok)) begin
      exp_rsp_q.push_back({1'b1, 1'b1, 32'h0});
    end else begin
      wa0 = a[31:2];
      be0 = '0; be1 = '0; wd0 = '0; wd1 = '0; rd = '0;
      for (int k = 0; k < n; k++) begin
        ba = a + 32'(k);
        if (ba[31:2] == wa0) begin
          be0[ba[1:0]] = 1'b1;
          wd0[8*ba[1:0] +: 8] = wd[8*k +: 8];
        end else begin
          be1[ba[1:0]] = 1'b1;
          wd1[8*ba[1:0] +: 8] = wd[8*k +: 8];
        end
        rd[8*k +: 8] = byte_at(ba);
      end
      exp_mem_q.push_back({wa0, is_wr, be0, wd0});
      if (crosses) exp_mem_q.push_back({wa0 + 30'd1, is_wr, be1, wd1});
      exp_rsp_q.push_back({~is_wr, 1'b0, is_wr ? 32'h0 : rd});
    end
  endtask

  // ---------------- memory responder ----------------
  always @(posedge clock) begin
    #1;
    if (!reset && bus.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_rd(bus.mem_addr);
        wait_cnt      = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      wait_cnt      = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    logic [66:0] e;
    logic [33:0] r;
    if (!reset) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_mem_q.size() == 0) begin
          check("unexpected_mem_txn", {bus.mem_we, bus.mem_be}, 64'h0);
        end else begin
          e = exp_mem_q.pop_front();
          check("txn_addr", bus.mem_addr, e[66:37]);
          check("txn_we",   bus.mem_we,   e[36]);
          check("txn_be",   bus.mem_be,   e[35:32]);
          if (e[36]) check("txn_wdata", bus.mem_wdata & lane_mask(e[35:32]), e[31:0]);
        end
        prev_be    = last_be;
        last_addr  = bus.mem_addr;
        last_be    = bus.mem_be;
        last_wdata = bus.mem_wdata;
        last_we    = bus.mem_we;
        txn_cnt++;
      end
      if (bus.core_ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_ready", bus.core_ready, 64'h0);
        end else begin
          r = exp_rsp_q.pop_front();
          check("rsp_err", bus.misalign_err, r[32]);
          if (r[33]) check("rsp_rdata", bus.core_rdata, r[31:0]);
        end
        last_rdata = bus.core_rdata;
        last_err   = bus.misalign_err;
      end else begin
        check("idle_rdata_err", {bus.core_rdata, bus.misalign_err}, 64'h0);
      end
      if (state_o == ST_IDLE) check("idle_no_req", bus.mem_req, 64'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd,
                       input logic rd, input logic wr, output int lat, output logic req_first);
    int waits;
    model_request(a, w, wd, wr);
    bus.core_address = a;
    bus.core_width   = w;
    bus.core_wdata   = wd;
    bus.core_read    = rd;
    bus.core_write   = wr;
    lat = 0; req_first = 1'b0; waits = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (i == 1) req_first = bus.mem_req;
      if (bus.mem_req && !bus.mem_ack) waits++;
      if (bus.core_ready) begin
        lat = i;
        break;
      end
    end
    last_waits = waits;
    if (lat == 0) begin
      check("ready_timeout", 64'h0, 64'h1);
      exp_mem_q.delete();
      exp_rsp_q.delete();
    end
  endtask

  task automatic idle_core();
    bus.core_read  = 1'b0;
    bus.core_write = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          lat, lat2;
    logic        rf, rf2;
    int          txn_before;
    logic [31:0] wd;

    bus.core_address = '0;
    bus.core_width   = '0;
    bus.core_wdata   = '0;
    bus.core_read    = 1'b0;
    bus.core_write   = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    settle();

    check("rst_core_ready", bus.core_ready, 64'h0);
    check("rst_core_rdata", bus.core_rdata, 64'h0);
    check("rst_mem_req",    bus.mem_req,    64'h0);
    check("rst_mem_be",     bus.mem_be,     64'h0);
    check("rst_mem_addr",   bus.mem_addr,   64'h0);
    check("rst_err",        bus.misalign_err, 64'h0);
    check("rst_state",      64'(state_o),   64'(ST_IDLE));

    // lw 0x100, zero-wait
    mem_m[30'h40] = 32'hDEAD_BEEF;
    issue(32'h100, WIDTH_WORD, 32'h0, 1'b1, 1'b0, lat, rf);
    idle_core(); settle();
    check("lw_latency", lat, 1);
    check("lw_addr", last_addr, 30'h40);
    check("lw_be", last_be, 4'b1111);
    check("lw_rdata", last_rdata, 32'hDEAD_BEEF);

    // sb 0x103
    issue(32'h103, WIDTH_BYTE, 32'h0000_00A5, 1'b0, 1'b1, lat, rf);
    idle_core(); settle();
    check("sb_be", last_be, 4'b1000);
    check("sb_wdata", last_wdata, 32'hA500_0000);
    check("sb_we", last_we, 1'b1);

    // lh 0x102 with ack three cycles late
    mem_m[30'h40] = 32'h1234_ABCD;
    ack_delay = 3;
    issue(32'h102, WIDTH_HALF, 32'h0, 1'b1, 1'b0, lat, rf);
    idle_core(); settle();
    check("lh_wait_cycles", last_waits, 3);
    check("lh_latency", lat, 4);
    check("lh_rdata", last_rdata, 32'h0000_1234);
    ack_delay = 0;

    // lw 0x101, crosses into word 0x41
    mem_m[30'h40] = 32'h3322_11EE;
    mem_m[30'h41] = 32'hABCD_EF44;
    txn_before = txn_cnt;
    issue(32'h101, WIDTH_WORD, 32'h0, 1'b1, 1'b0, lat, rf);
    idle_core(); settle();
`ifdef MISALIGNED_SPLIT_EN
    check("split_latency", lat, 2);
    check("split_ph0_be", prev_be, 4'b1110);
    check("split_ph1_addr", last_addr, 30'h41);
    check("split_ph1_be", last_be, 4'b0001);
    check("split_rdata", last_rdata, 32'h4433_2211);
    check("split_txns", txn_cnt - txn_before, 2);
`else
    check("misalign_latency", lat, 1);
    check("misalign_no_req", rf, 1'b0);
    check("misalign_err", last_err, 1'b1);
    check("misalign_rdata", last_rdata, 32'h0);
    check("misalign_txns", txn_cnt - txn_before, 0);
`endif

    // back-to-back sw 0x200 then lw 0x204
    mem_m[30'h81] = 32'hCAFE_F00D;
    issue(32'h200, WIDTH_WORD, 32'h1122_3344, 1'b0, 1'b1, lat, rf);
    issue(32'h204, WIDTH_WORD, 32'h0, 1'b1, 1'b0, lat2, rf2);
    idle_core(); settle();
    check("b2b_first_latency", lat, 1);
    check("b2b_second_latency", lat2, 1);
    check("b2b_req_no_gap", rf2, 1'b1);
    check("b2b_rdata", last_rdata, 32'hCAFE_F00D);

    // address wrap at the top of memory
    mem_m[30'h3FFF_FFFF] = 32'h8877_6655;
    mem_m[30'h0]         = 32'h0403_0201;
    issue(32'hFFFF_FFFE, WIDTH_HALF, 32'h0, 1'b1, 1'b0, lat, rf);
    idle_core(); settle();
    check("top_lh_rdata", last_rdata, 32'h0000_8877);
    issue(32'hFFFF_FFFD, WIDTH_WORD, 32'h0, 1'b1, 1'b0, lat, rf);
    idle_core(); settle();
`ifdef MISALIGNED_SPLIT_EN
    check("wrap_addr", last_addr, 30'h0);
    check("wrap_rdata", last_rdata, 32'h0188_7766);
`else
    check("wrap_err", last_err, 1'b1);
`endif

    // read and write together act as a write; illegal width
    issue(32'h20C, WIDTH_WORD, 32'h5566_7788, 1'b1, 1'b1, lat, rf);
    idle_core(); settle();
    check("rw_is_write", last_we, 1'b1);
    txn_before = txn_cnt;
    issue(32'h210, WIDTH_ILLEGAL, 32'h1, 1'b0, 1'b1, lat, rf);
    idle_core(); settle();
    check("illegal_latency", lat, 1);
    check("illegal_err", last_err, 1'b1);
    check("illegal_no_txn", txn_cnt - txn_before, 0);

    // sweep widths, offsets and directions back to back with varied ack delays
    for (int w = 0; w < 4; w++) begin
      for (int off = 0; off < 4; off++) begin
        for (int wr = 0; wr < 2; wr++) begin
          ack_delay = (w + off + wr) % 3;
          wd = $urandom;
          issue(32'h300 + 32'(8 * w) + 32'(off), 2'(w), wd, wr == 0, wr == 1, lat, rf);
        end
      end
    end
    idle_core(); settle();
    ack_delay = 0;

    // reset while PH0 waits for an ack
    ack_delay = 10;
    bus.core_address = 32'h100;
    bus.core_width   = WIDTH_WORD;
    bus.core_read    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("pre_reset_req", bus.mem_req, 1'b1);
    idle_core();
    #2 reset = 1'b1;
    #1;
    check("reset_drops_req", bus.mem_req, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    settle();
    check("post_rst_state", 64'(state_o), 64'(ST_IDLE));
    check("post_rst_outputs",
          {bus.core_ready, bus.misalign_err, bus.mem_req, bus.mem_we, bus.mem_be},
          64'h0);
    check("post_rst_data", {bus.core_rdata, bus.mem_wdata}, 64'h0);
    ack_delay = 0;

    issue(32'h100, WIDTH_WORD, 32'h0, 1'b1, 1'b0, lat, rf);
    idle_core(); settle();
    check("recover_rdata", last_rdata, 32'h3322_11EE);

    repeat (2) @(negedge clock);
    check("mem_queue_drained", exp_mem_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_adapter.md
Name: data_bus_adapter

Overview:
- Sits directly downstream of the core's data port (stage-2 load/store).
- Converts the core's byte-addressed, width-coded requests into word-addressed memory transactions with byte enables.
- Write data is lane-shifted; read data is returned right-aligned and zero-extended. The core performs sign extension.
- Optionally splits misaligned half/word accesses into two word transactions.

Parameters:
- ADDR_W, 30: width of the word address on the memory side; equals mem_addr width. The core address supplies bits [ADDR_W+1:2].

Ports:
- clock  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- core_address  input  32  byte address from the core.
- core_width  input  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
- core_wdata  input  32  store data, right-aligned.
- core_read  input  1  load request.
- core_write  input  1  store request.
- core_rdata  output  32  load result, right-aligned, zero-extended.
- core_ready  output  1  request complete in this cycle.
- mem_addr  output  ADDR_W  word address.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = write.
- mem_be  output  4  byte enables, bit i = byte lane i.
- mem_wdata  output  32  lane-positioned write data.
- mem_rdata  input  32  read word; valid when mem_ack = 1.
- mem_ack  input  1  transaction done; may assert in the same cycle as mem_req.
- misalign_err  output  1  one-cycle pulse with core_ready for an unsupported or illegal access.

Behaviour:
- States: IDLE, PH0 (first/only word), PH1 (second word of a split).
- Reset value of every output is 0. Reset forces IDLE immediately.
  - Reset mid-transaction drops mem_req asynchronously; the memory must tolerate an abandoned request.
- Acceptance: at a clock edge, a request is captured when core_read|core_write = 1 and either:
  - state is IDLE, or
  - core_ready = 1 in that cycle (back-to-back pipelining).
- While busy and core_ready = 0, core inputs are ignored; the core is re-driving the same held request.
- Captured fields: address, width, wdata, write flag, offset = address[1:0]. Next state is PH0.
- If core_read and core_write are both 1, it is treated as a write.
- PH0:
  - mem_req = 1, mem_addr = addr[ADDR_W+1:2].
  - mem_be = base mask << offset, masked to 4 bits. Base mask: byte 0001, half 0011, word 1111.
  - mem_wdata = wdata << 8*offset.
  - Leaves PH0 only on mem_ack.
- Misaligned (half with offset 3, word with offset ≠ 0):
  - PH0 covers lanes offset..3.
  - Low bytes are captured: lo = mem_rdata >> 8*offset.
  - Then go to PH1.
- PH1:
  - mem_addr = word address + 1, wrapping modulo 2^ADDR_W (0x3FFFFFFF → 0).
  - mem_be = remaining low lanes.
  - mem_wdata = wdata >> 8*(4-offset).
  - On mem_ack the access completes.
- Completion (combinational): core_ready = mem_ack in the final phase; core_rdata is valid in the same cycle.
  - Aligned: (mem_rdata >> 8*offset) & width mask.
  - Split: (lo | mem_rdata << 8*(4-offset)) & width mask.
  - Width masks: FF, FFFF, FFFFFFFF.
- Next state after completion: PH0 if a new request is accepted at that edge, otherwise IDLE.
- Latency: a zero-wait memory (ack in the mem_req cycle) gives core_ready in the cycle after the request is issued, so aligned accesses cause no core stall. A split adds exactly 1 cycle.
- core_ready = 0 and core_rdata = 0 outside completion cycles.
- mem_req is never asserted in IDLE.
- Width 3: treated as word, but mem_be = 0000, no memory transaction, and core_ready + misalign_err asserted in the PH0 cycle without waiting for mem_ack.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined: misaligned accesses are split as described above.
- Undefined:
  - PH1 does not exist.
  - A misaligned access issues no memory transaction: mem_req stays 0 and writes are suppressed.
  - core_ready = 1 and misalign_err = 1 in the PH0 cycle; core_rdata = 0.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - width codes WIDTH_BYTE/HALF/WORD;
  - state encodings;
  - base byte-mask and data-mask constants.
- Sub-module lane_align (combinational) computes mem_be, shifted wdata and aligned rdata from offset, width and phase. It is instantiated once.

Test Plan:
- Zero-wait memory, lw at 0x100 with mem_rdata = 0xDEADBEEF → mem_addr = 0x40, mem_be = 1111, core_ready in the next cycle, core_rdata = 0xDEADBEEF.
- sb at 0x103, core_wdata = 0x000000A5 → mem_be = 1000, mem_wdata = 0xA5000000, mem_we = 1.
- lh at 0x102 with mem_rdata = 0x1234ABCD and mem_ack delayed 3 cycles → mem_req held for 3 cycles, core_ready only on the ack cycle, core_rdata = 0x00001234.
- With MISALIGNED_SPLIT_EN, lw at 0x101: word0 = 0x332211XX, word1 = 0xYYYYYY44.
  - PH0 mem_be = 1110; PH1 mem_addr = 0x41, mem_be = 0001.
  - core_rdata = 0x44332211; 2-cycle latency.
- Same access without the macro → no mem_req, core_ready = 1, misalign_err = 1, core_rdata = 0.
- Back-to-back sw 0x200 then lw 0x204 with zero-wait memory → two consecutive mem_req cycles with no IDLE gap.
- Reset asserted during a PH0 wait → mem_req drops immediately; after release, state is IDLE and all outputs are 0.
